// File: rtl/coin_acceptor.sv
// Coin-mechanism front end: synchronizes and debounces the two slot sensors and issues one
// registered coin code per physical coin. It also rejects ambiguous coins and flags a jam.
module coin_acceptor #(
   parameter int unsigned DEBOUNCE_CYCLES = 4,
   parameter int unsigned GAP_CYCLES      = 3,
   parameter int unsigned JAM_CYCLES      = 64
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       sense_one,
   input  logic       sense_two,
   output logic [1:0] coin,
   output logic       reject,
   output logic       jam,
   output logic [7:0] coin_count
);

   localparam logic [2:0] IDLE    = 3'd0;
   localparam logic [2:0] QUAL    = 3'd1;
   localparam logic [2:0] EMIT    = 3'd2;
   localparam logic [2:0] REJECT  = 3'd3;
   localparam logic [2:0] RELEASE = 3'd4;
   localparam logic [2:0] JAM     = 3'd5;

   localparam logic [7:0] DEB_LIM = 8'(DEBOUNCE_CYCLES);
   localparam logic [7:0] GAP_LIM = 8'(GAP_CYCLES);
   localparam logic [7:0] JAM_LIM = 8'(JAM_CYCLES);

   logic       sync_one, sync_two, s1, s2;
   logic [2:0] state, state_d;
   logic [1:0] coin_type, coin_type_d;
   logic [7:0] qcnt, qcnt_d, rcnt, rcnt_d, jcnt, jcnt_d;
   logic [1:0] coin_d;
   logic       reject_d, jam_d;
   logic [7:0] coin_count_d;
   logic       latched_high;

   assign latched_high = (coin_type == 2'b01) ? s1 : s2;

   always_comb begin
      state_d      = state;
      coin_type_d  = coin_type;
      qcnt_d       = qcnt;
      rcnt_d       = rcnt;
      jcnt_d       = jcnt;
      coin_d       = 2'b00;
      reject_d     = 1'b0;
      jam_d        = jam;
      coin_count_d = coin_count;
      case (state)
         IDLE: begin
            if (s1 && s2) begin
               state_d = REJECT;
            end else if (s1 != s2) begin
               coin_type_d = s1 ? 2'b01 : 2'b10;
               qcnt_d      = 8'd1;
               if (DEB_LIM == 8'd1) begin
                  state_d      = EMIT;
                  coin_d       = coin_type_d;
                  coin_count_d = coin_count + 8'd1;
               end else begin
                  state_d = QUAL;
               end
            end
         end
         QUAL: begin
            if (s1 && s2) begin
               state_d = REJECT;
            end else if (!latched_high) begin
               state_d = IDLE;
            end else begin
               qcnt_d = qcnt + 8'd1;
               if (qcnt_d == DEB_LIM) begin
                  state_d      = EMIT;
                  coin_d       = coin_type;
                  coin_count_d = coin_count + 8'd1;
               end
            end
         end
         EMIT: begin
            state_d = RELEASE;
            rcnt_d  = 8'd0;
            jcnt_d  = 8'd0;
         end
         REJECT: begin
            // The reject pulse trails the decision by one cycle, issued from this state.
            reject_d = 1'b1;
            state_d  = RELEASE;
            rcnt_d   = 8'd0;
            jcnt_d   = 8'd0;
         end
         RELEASE: begin
            if (s1 || s2) begin
               rcnt_d = 8'd0;
               jcnt_d = jcnt + 8'd1;
               if (jcnt_d == JAM_LIM) begin
                  state_d = JAM;
                  jam_d   = 1'b1;
               end
            end else begin
               rcnt_d = rcnt + 8'd1;
               if (rcnt_d == GAP_LIM) state_d = IDLE;
            end
         end
         JAM: begin
            if (s1 || s2) begin
               rcnt_d = 8'd0;
            end else begin
               rcnt_d = rcnt + 8'd1;
               if (rcnt_d == GAP_LIM) begin
                  state_d = IDLE;
                  jam_d   = 1'b0;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         sync_one   <= 1'b0;
         sync_two   <= 1'b0;
         s1         <= 1'b0;
         s2         <= 1'b0;
         state      <= IDLE;
         coin_type  <= 2'b00;
         qcnt       <= 8'd0;
         rcnt       <= 8'd0;
         jcnt       <= 8'd0;
         coin       <= 2'b00;
         reject     <= 1'b0;
         jam        <= 1'b0;
         coin_count <= 8'd0;
      end else begin
         sync_one   <= sense_one;
         sync_two   <= sense_two;
         s1         <= sync_one;
         s2         <= sync_two;
         state      <= state_d;
         coin_type  <= coin_type_d;
         qcnt       <= qcnt_d;
         rcnt       <= rcnt_d;
         jcnt       <= jcnt_d;
         coin       <= coin_d;
         reject     <= reject_d;
         jam        <= jam_d;
         coin_count <= coin_count_d;
      end
   end

endmodule

// File: doc/coin_acceptor.md
# coin_acceptor

Front-end stage that turns the raw coin-mechanism sensor lines into the clean `coin[1:0]` code consumed directly by `vending_machine`. It synchronizes and debounces two sensor inputs (1-unit and 2-unit slots), emits exactly one single-cycle coin code per physical coin, and rejects coins that are ambiguous. It also flags a jammed mechanism and keeps a running count of accepted coins. It sits between the coin-mechanism pins and `vending_machine`, on the same clock.

## Interface
- `DEBOUNCE_CYCLES`, default 4: consecutive synchronized-high samples required to accept a coin (range 1–255).
- `GAP_CYCLES`, default 3: consecutive both-low samples required before the next coin is accepted (range 1–255).
- `JAM_CYCLES`, default 64: cycles a sensor may stay high after acceptance before `jam` is raised (range greater than `DEBOUNCE_CYCLES`, up to 255).

Ports:
- `clock` in 1: system clock, rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `sense_one` in 1: raw 1-unit slot sensor, asynchronous to `clock`.
- `sense_two` in 1: raw 2-unit slot sensor, asynchronous to `clock`.
- `coin` out 2: 2'b00 none, 2'b01 one unit, 2'b10 two units; 2'b11 is never driven. Connects to `vending_machine` coin input.
- `reject` out 1: one-cycle pulse when a coin is refused.
- `jam` out 1: level signal; mechanism stuck.
- `coin_count` out 8: number of accepted coins, wraps 255→0.

## Operation
- **Synchronizers.** Each sense line passes through a 2-flop synchronizer, giving `s1` and `s2`. All FSM decisions use `s1`/`s2` only.
- **States:** IDLE, QUAL, EMIT, REJECT, RELEASE, JAM. A qualification counter `qcnt` and a release counter `rcnt` are each 8 bits.
- **IDLE**
  - Exactly one of `s1`/`s2` high: latch the type (1 or 2), set `qcnt` to 1, go to QUAL.
  - Both high: go to REJECT.
  - Neither high: stay in IDLE.
- **QUAL**
  - Both high: go to REJECT.
  - Latched line low: glitch. Return to IDLE with no output.
  - Latched line still high and the other low: increment `qcnt`. When `qcnt` would reach `DEBOUNCE_CYCLES`, go to EMIT.
  - `DEBOUNCE_CYCLES`=1: IDLE goes straight to EMIT.
- **EMIT**
  - `coin` = the latched type for exactly one cycle.
  - `coin_count` increments by 1 (mod 256).
  - Next state is RELEASE; clear `rcnt` and the jam timer.
- **REJECT**
  - `reject` = 1 for exactly one cycle; `coin` stays 00.
  - Next state is RELEASE.
- **RELEASE**
  - Both low: increment `rcnt`.
  - Either line high: clear `rcnt` and increment the jam timer.
  - `rcnt` reaches `GAP_CYCLES`: go to IDLE.
  - Jam timer reaches `JAM_CYCLES`: go to JAM.
- **JAM**
  - `jam` = 1.
  - Leave only after `GAP_CYCLES` consecutive both-low samples: go to IDLE with `jam` = 0.
  - Lines toggling inside JAM never produce `coin` or `reject`.
- **Invariants**
  - `coin` is non-zero only in the EMIT cycle.
  - `coin` and `reject` are never both active in the same cycle.
  - At most one `coin` or `reject` event per sense assertion.
- All outputs are registered.

## Timing
- **Reset values** (applied asynchronously and held while `reset`=1):
  - `coin`=00, `reject`=0, `jam`=0, `coin_count`=0.
  - State IDLE; synchronizers, `qcnt`, `rcnt` and the jam timer all 0.
- **Reset mid-operation.** An in-flight EMIT or REJECT is cancelled and no pulse appears. After release, the first acceptance needs the full synchronize-and-debounce sequence.
- **Acceptance latency.** Let E0 be the first edge that samples a raw line high.
  - `coin` is valid from edge E(DEBOUNCE_CYCLES+1) to edge E(DEBOUNCE_CYCLES+2); with defaults, E5 to E6.
  - The raw line must be high at edges E0..E(DEBOUNCE_CYCLES-1).
- **Reject latency.** `reject` is high from E3 to E4 when both lines rise at E0.
- **Minimum coin spacing.** After the `coin` pulse, the next acceptance needs at least `GAP_CYCLES` both-low synchronized samples plus the full debounce.
- **Jam raise.** `jam` rises on the edge where the jam timer reaches `JAM_CYCLES`.
- **Jam clear.** `jam` falls on the edge that completes the `GAP_CYCLES`-th consecutive both-low sample.
- **Simultaneous events**
  - Second line rising during QUAL: REJECT wins.
  - A line still high at the moment of acceptance, in EMIT: ignored; it is handled by RELEASE.

## Test plan
1. **Single 1-unit coin.** Pulse `sense_one` high for 6 cycles at defaults → one `coin`=01 pulse starting 5 edges after first sample, `coin_count`=1, `reject`=0.
2. **Glitch rejection.** Pulse `sense_two` high for 2 cycles → `coin` stays 00, no `reject`, `coin_count` unchanged.
3. **Ambiguous coin.** Raise `sense_one` and `sense_two` together for 6 cycles → one `reject` pulse, `coin` stays 00; both lines low for 3 cycles returns to IDLE.
4. **Back-to-back mixed coins** matching the vending sequence. Drive 1,1,2,1 each 6 high / 4 low → `coin` pulses 01,01,10,01 in order, `coin_count`=4.
5. **Jam.** Hold `sense_one` high for 80 cycles → one `coin`=01, `jam` rises 64 cycles after leaving EMIT. Release → `jam` clears after 3 low samples, and the next coin is accepted normally.
6. **Reset mid-operation.** Assert `reset` during QUAL and again during EMIT → `coin` goes to 00 immediately, `coin_count`=0, no pulse after release.
